acc_traffic_driver: RTL and testbench

- Initiator/checker for the accelerator decoupled valid/ready data path: the opposite end of an accelerator unit.
- Drives a programmed number of data beats into the accelerator's consumer port as master, then drains the expected number of beats from its producer port as slave.
- Reports received count, XOR signature, completion and timeout status.
- Used in the fifo_controller acc_unit area as an on-chip stimulus source and bring-up checker for dummy and real accelerator stages.

---
 rtl/acc_traffic_driver.sv | 191 +++++++++++++++++++
 tb/tb_acc_traffic_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_traffic_driver.sv
// acc_traffic_driver
//   On-chip stimulus source and bring-up checker for an accelerator stage.
//   It sends a programmed number of incrementing data beats into the
//   accelerator's consumer port. It then drains a programmed number of beats
//   from the accelerator's producer port. For the received beats it keeps a
//   beat count and an XOR signature. A run that stalls for too long is ended
//   by a timeout.
//
//   Optional build macro: ACC_TRAFFIC_DRIVER_BACKPRESSURE_EN
//     When defined, rx_ready is asserted only every other S_RECV cycle,
//     starting with the first one. This exercises backpressure on the
//     producer side.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle launch pulse (ignored while busy)
//   send_beats      beats to transmit        (sampled at start)
//   recv_beats      beats to receive         (sampled at start)
//   seed            first transmit data word (sampled at start)
//   timeout_cycles  stall limit, 0 = no timeout (sampled at start)
//   tx_valid/tx_ready/tx_data   master side toward the accelerator
//   rx_valid/rx_ready/rx_data   slave side from the accelerator
//   busy, done      run status
//   err_timeout     last run ended by timeout (sticky until next start)
//   rx_count        beats received in the current/last run
//   rx_xor          XOR of all received beats
module acc_traffic_driver #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16,
  parameter int TO_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  send_beats,
  input  logic [CNT_W-1:0]  recv_beats,
  input  logic [DATA_W-1:0] seed,
  input  logic [TO_W-1:0]   timeout_cycles,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  rx_count,
  output logic [DATA_W-1:0] rx_xor
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_send_beats;
  logic [CNT_W-1:0]  r_recv_beats;
  logic [TO_W-1:0]   r_timeout;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_rx_count;
  logic [DATA_W-1:0] r_rx_xor;
  logic              r_err_timeout;

  logic              w_rx_ready;
  logic              w_tx_hs;
  logic              w_rx_hs;
  logic              w_stall;
  logic              w_to_hit;
  logic [CNT_W-1:0]  w_tx_cnt_inc;
  logic [CNT_W-1:0]  w_rx_cnt_inc;
  logic [TO_W-1:0]   w_to_inc;

`ifdef ACC_TRAFFIC_DRIVER_BACKPRESSURE_EN
  logic r_toggle;

  // The toggle is zero whenever we are outside S_RECV. Entry into S_RECV
  // therefore always starts with ready high, and ready alternates after that.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_toggle <= 1'b0;
    end else if (r_state == S_RECV) begin
      r_toggle <= ~r_toggle;
    end else begin
      r_toggle <= 1'b0;
    end
  end

  assign w_rx_ready = (r_state == S_RECV) & ~r_toggle;
`else
  assign w_rx_ready = (r_state == S_RECV);
`endif

  assign tx_valid    = (r_state == S_SEND);
  assign rx_ready    = w_rx_ready;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state == S_SEND) | (r_state == S_RECV);
  assign done        = (r_state == S_DONE);
  assign err_timeout = r_err_timeout;
  assign rx_count    = r_rx_count;
  assign rx_xor      = r_rx_xor;

  assign w_tx_hs      = tx_valid & tx_ready;
  assign w_rx_hs      = w_rx_ready & rx_valid;
  assign w_tx_cnt_inc = r_tx_cnt + CNT_W'(1);
  assign w_rx_cnt_inc = r_rx_count + CNT_W'(1);
  assign w_to_inc     = r_to_cnt + TO_W'(1);

  // A stall is a cycle where our side offers a transfer and the other side
  // does not take it. With backpressure enabled, rx_ready-low cycles are not
  // stalls.
  assign w_stall  = (tx_valid & ~tx_ready) | (w_rx_ready & ~rx_valid);
  assign w_to_hit = w_stall & (r_timeout != '0) & (w_to_inc == r_timeout);

  // Main run sequencer. A handshake is checked before the timeout, so a
  // transfer that lands on the last allowed cycle still counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_send_beats  <= '0;
      r_recv_beats  <= '0;
      r_timeout     <= '0;
      r_tx_cnt      <= '0;
      r_to_cnt      <= '0;
      r_tx_data     <= '0;
      r_rx_count    <= '0;
      r_rx_xor      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_send_beats  <= send_beats;
            r_recv_beats  <= recv_beats;
            r_timeout     <= timeout_cycles;
            r_tx_cnt      <= '0;
            r_to_cnt      <= '0;
            r_tx_data     <= seed;
            r_rx_count    <= '0;
            r_rx_xor      <= '0;
            r_err_timeout <= 1'b0;
            if (send_beats != '0) begin
              r_state <= S_SEND;
            end else if (recv_beats != '0) begin
              r_state <= S_RECV;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (w_tx_hs) begin
            r_tx_cnt  <= w_tx_cnt_inc;
            r_tx_data <= r_tx_data + DATA_W'(1);
            r_to_cnt  <= '0;
            if (w_tx_cnt_inc == r_send_beats) begin
              r_state <= (r_recv_beats != '0) ? S_RECV : S_DONE;
            end
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= S_DONE;
          end else if (w_stall) begin
            r_to_cnt <= w_to_inc;
          end
        end
        S_RECV: begin
          if (w_rx_hs) begin
            r_rx_count <= w_rx_cnt_inc;
            r_rx_xor   <= r_rx_xor ^ rx_data;
            r_to_cnt   <= '0;
            if (w_rx_cnt_inc == r_recv_beats) begin
              r_state <= S_DONE;
            end
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= S_DONE;
          end else if (w_stall) begin
            r_to_cnt <= w_to_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_traffic_driver.sv
// tb_acc_traffic_driver
//   Directed bench for acc_traffic_driver. It uses hand-computed expected
//   values and immediate-assertion checks.
module tb_acc_traffic_driver;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam int TO_W   = 14;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  send_beats;
  logic [CNT_W-1:0]  recv_beats;
  logic [DATA_W-1:0] seed;
  logic [TO_W-1:0]   timeout_cycles;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic [CNT_W-1:0]  rx_count;
  logic [DATA_W-1:0] rx_xor;

  int checkCount;
  int passCount;

  acc_traffic_driver #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .TO_W  (TO_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .send_beats    (send_beats),
    .recv_beats    (recv_beats),
    .seed          (seed),
    .timeout_cycles(timeout_cycles),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout),
    .rx_count      (rx_count),
    .rx_xor        (rx_xor)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Pulse start for one cycle with the given run configuration
  task automatic applyStimulus(input logic [CNT_W-1:0] nSend, input logic [CNT_W-1:0] nRecv,
                               input logic [DATA_W-1:0] firstWord, input logic [TO_W-1:0] toCycles);
    send_beats     = nSend;
    recv_beats     = nRecv;
    seed           = firstWord;
    timeout_cycles = toCycles;
    start          = 1'b1;
    stepClk();
    start          = 1'b0;
  endtask

  // Drives the test sequence and checks each step against the expected values.
  initial begin
    logic [7:0] rdyPattern;
    int         rdyLen;
    logic [DATA_W-1:0] allOnes;

    checkCount     = 0;
    passCount      = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    send_beats     = '0;
    recv_beats     = '0;
    seed           = '0;
    timeout_cycles = '0;
    tx_ready       = 1'b0;
    rx_valid       = 1'b0;
    rx_data        = '0;
    #1;

    // Reset state
    stepClk();
    stepClk();
    checkOutput("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    checkOutput("rst_tx_data", tx_data, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_err", {63'd0, err_timeout}, 64'd0);
    checkOutput("rst_rx_count", {48'd0, rx_count}, 64'd0);
    checkOutput("rst_rx_xor", rx_xor, 64'd0);
    rst_n = 1'b1;
    stepClk();
    checkOutput("idle_done", {63'd0, done}, 64'd0);

    // Run 1: send 4, recv 2, free-flowing handshakes
    $display("[TB] run 1: send=4 recv=2 seed=0x10");
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 64'hA;
    applyStimulus(16'd4, 16'd2, 64'h10, 14'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("r1_tx_valid", {63'd0, tx_valid}, 64'd1);
      checkOutput("r1_tx_data", tx_data, 64'h10 + 64'(i));
      checkOutput("r1_rx_ready_low", {63'd0, rx_ready}, 64'd0);
      stepClk();
    end
    checkOutput("r1_tx_valid_off", {63'd0, tx_valid}, 64'd0);
    checkOutput("r1_rx_ready", {63'd0, rx_ready}, 64'd1);
    stepClk();
    rx_data = 64'h5;
    checkOutput("r1_rx_count1", {48'd0, rx_count}, 64'd1);
    checkOutput("r1_not_done", {63'd0, done}, 64'd0);
    stepClk();
    checkOutput("r1_done", {63'd0, done}, 64'd1);
    checkOutput("r1_busy", {63'd0, busy}, 64'd0);
    checkOutput("r1_rx_count", {48'd0, rx_count}, 64'd2);
    checkOutput("r1_rx_xor", rx_xor, 64'hF);
    checkOutput("r1_err", {63'd0, err_timeout}, 64'd0);
    checkOutput("r1_rx_ready_after", {63'd0, rx_ready}, 64'd0);
    stepClk();
    checkOutput("r1_count_hold", {48'd0, rx_count}, 64'd2);

    // Run 2: send 3 with tx_ready every 3rd cycle, timeout 5 never reached
    $display("[TB] run 2: send=3 sparse tx_ready timeout=5");
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    applyStimulus(16'd3, 16'd0, 64'h20, 14'd5);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) begin
        tx_ready = (k == 2);
        checkOutput("r2_tx_data", tx_data, 64'h20 + 64'(b));
        checkOutput("r2_err", {63'd0, err_timeout}, 64'd0);
        stepClk();
      end
    end
    tx_ready = 1'b0;
    checkOutput("r2_done", {63'd0, done}, 64'd1);
    checkOutput("r2_err_final", {63'd0, err_timeout}, 64'd0);
    checkOutput("r2_tx_data_final", tx_data, 64'h23);

    // Run 3: send 2, recv 1, rx_valid never arrives, timeout 4
    $display("[TB] run 3: receive timeout");
    tx_ready = 1'b1;
    rx_valid = 1'b0;
    applyStimulus(16'd2, 16'd1, 64'h30, 14'd4);
    stepClk();
    stepClk();
    for (int j = 0; j < 4; j++) begin
      checkOutput("r3_busy", {63'd0, busy}, 64'd1);
      checkOutput("r3_rx_ready", {63'd0, rx_ready}, 64'd1);
      checkOutput("r3_no_err_yet", {63'd0, err_timeout}, 64'd0);
      stepClk();
    end
    checkOutput("r3_err", {63'd0, err_timeout}, 64'd1);
    checkOutput("r3_done", {63'd0, done}, 64'd1);
    checkOutput("r3_rx_count", {48'd0, rx_count}, 64'd0);

    // Run 4: zero-beat run, then a 5-beat run with an ignored start
    $display("[TB] run 4: zero-beat run and ignored start");
    applyStimulus(16'd0, 16'd0, 64'h0, 14'd0);
    checkOutput("r4_done", {63'd0, done}, 64'd1);
    checkOutput("r4_tx_valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("r4_rx_ready", {63'd0, rx_ready}, 64'd0);
    checkOutput("r4_err_cleared", {63'd0, err_timeout}, 64'd0);
    applyStimulus(16'd5, 16'd0, 64'h40, 14'd0);
    checkOutput("r4_tx_data0", tx_data, 64'h40);
    send_beats = 16'd1;
    seed       = 64'h99;
    start      = 1'b1;
    stepClk();
    start = 1'b0;
    checkOutput("r4_ignored_start", tx_data, 64'h41);
    checkOutput("r4_still_busy", {63'd0, busy}, 64'd1);
    stepClk();
    stepClk();
    stepClk();
    checkOutput("r4_before_last", {63'd0, done}, 64'd0);
    stepClk();
    checkOutput("r4_done5", {63'd0, done}, 64'd1);
    checkOutput("r4_tx_data_final", tx_data, 64'h45);

    // Run 5: data wrap, then reset in the middle of S_SEND
    $display("[TB] run 5: seed wrap and mid-run reset");
    allOnes = '1;
    applyStimulus(16'd2, 16'd0, allOnes, 14'd0);
    checkOutput("r5_tx_data_max", tx_data, allOnes);
    stepClk();
    checkOutput("r5_tx_data_wrap", tx_data, 64'd0);
    checkOutput("r5_mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    stepClk();
    checkOutput("r5_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    checkOutput("r5_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("r5_rst_done", {63'd0, done}, 64'd0);
    checkOutput("r5_rst_tx_data", tx_data, 64'd0);
    rst_n = 1'b1;
    tx_ready = 1'b0;
    stepClk();

    // Run 6: receive-only run of 3 beats with rx_valid held high
    $display("[TB] run 6: receive-only recv=3");
`ifdef ACC_TRAFFIC_DRIVER_BACKPRESSURE_EN
    rdyPattern = 8'b0001_0101;
    rdyLen     = 5;
`else
    rdyPattern = 8'b0000_0111;
    rdyLen     = 3;
`endif
    rx_valid = 1'b1;
    rx_data  = 64'h1;
    applyStimulus(16'd0, 16'd3, 64'h0, 14'd0);
    for (int c = 0; c < rdyLen; c++) begin
      checkOutput("r6_rx_ready", {63'd0, rx_ready}, {63'd0, rdyPattern[c]});
      checkOutput("r6_not_done", {63'd0, done}, 64'd0);
      stepClk();
      if (rx_count == 16'd1) rx_data = 64'h2;
      if (rx_count == 16'd2) rx_data = 64'h4;
    end
    checkOutput("r6_done", {63'd0, done}, 64'd1);
    checkOutput("r6_rx_count", {48'd0, rx_count}, 64'd3);
    checkOutput("r6_rx_xor", rx_xor, 64'h7);
    rx_valid = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
